// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stall masks for the pipeline controller and its memory-port arbiter.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2,
        DROP_IF = 2'd3
    } arb_state_t;

    // Each mask freezes its own stage and every stage upstream of it.
    localparam logic [5:0] STALL_IF  = 6'b000011;
    localparam logic [5:0] STALL_ID  = 6'b000111;
    localparam logic [5:0] STALL_EX  = 6'b001111;
    localparam logic [5:0] STALL_MEM = 6'b011111;

endpackage

// File: rtl/pipe_ctrl_mem_port_arb.sv
// Single memory port arbiter between instruction fetch and the MEM stage,
// with starvation protection for fetch and squashing of stale fetches.
module mem_port_arb
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              branch_taken,
    input  logic              mem_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              if_done,
    output logic              ls_done,
    output arb_state_t        state,
    output logic [CNT_W-1:0]  starve_cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t state_nxt;
    logic       grant_ls;
    logic       grant_if;

    // Grants are only issued from IDLE, which guarantees one idle cycle between accesses.
    always_comb begin
        state_nxt = state;
        grant_ls  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (ls_req && !(if_req && starve_cnt == LIMIT)) begin
                    grant_ls  = 1'b1;
                    state_nxt = BUSY_LS;
                end else if (if_req && !branch_taken) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem_done) begin
                    state_nxt = IDLE;
                end else if (branch_taken) begin
                    state_nxt = DROP_IF;
                end
            end
            BUSY_LS, DROP_IF: begin
                if (mem_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ls) begin
                mem_req   <= 1'b1;
                mem_we    <= ls_we;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
                if (if_req && starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else if (grant_if) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                starve_cnt <= '0;
            end else if (state != IDLE && mem_done) begin
                mem_req <= 1'b0;
            end
        end
    end

    // A fetch completing alongside a taken branch is stale and never reported.
    assign if_done = mem_done && (state == BUSY_IF) && !branch_taken;
    assign ls_done = mem_done && (state == BUSY_LS);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall vector and branch flush around the
// shared memory port arbiter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              id_stall_req,
    input  logic              ex_stall_req,
    input  logic              branch_taken,
    output logic [5:0]        stall,
    output logic              flush,
    output arb_state_t        fsm_state,
    output logic [CNT_W-1:0]  starve_cnt
);

    logic ls_pend;
    logic if_pend;
    logic id_stall_q;

    mem_port_arb #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_arb (
        .CLK          (CLK),
        .RST          (RST),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .branch_taken (branch_taken),
        .mem_done     (mem_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .if_done      (if_done),
        .ls_done      (ls_done),
        .state        (fsm_state),
        .starve_cnt   (starve_cnt)
    );

    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;

    assign ls_pend    = ls_req && !ls_done;
    assign if_pend    = if_req && !if_done && !branch_taken;
    assign id_stall_q = id_stall_req && !branch_taken;

    // A branch under a MEM stall is held in EX and flushes once the stall releases.
    always_comb begin
        stall = '0;
        flush = 1'b0;
        if (RST) begin
            if (ls_pend)      stall = stall | STALL_MEM;
            if (ex_stall_req) stall = stall | STALL_EX;
            if (id_stall_q)   stall = stall | STALL_ID;
            if (if_pend)      stall = stall | STALL_IF;
            flush = branch_taken && !ls_pend;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: stall/flush vector table, memory-port
// sequences, and a grant scoreboard fed by the request stimulus.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              if_req, ls_req, ls_we, mem_done;
    logic              id_stall_req, ex_stall_req, branch_taken;
    logic [ADDR_W-1:0] if_addr, ls_addr;
    logic [DATA_W-1:0] ls_wdata, mem_rdata;
    logic              if_done, ls_done, mem_req, mem_we, flush;
    logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [5:0]        stall;
    arb_state_t        fsm_state;
    logic [CNT_W-1:0]  starve_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Expected memory-port grants: {we, addr, wdata}
    logic [ADDR_W+DATA_W:0] exp_q[$];
    logic                   mem_req_prev = 1'b0;

    typedef struct {
        logic       ls;
        logic       ifr;
        logic       id;
        logic       ex;
        logic       br;
        logic [5:0] stall;
        logic       flush;
    } vec_t;
    vec_t vt[12];

    pipe_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .id_stall_req(id_stall_req), .ex_stall_req(ex_stall_req),
        .branch_taken(branch_taken), .stall(stall), .flush(flush),
        .fsm_state(fsm_state), .starve_cnt(starve_cnt)
    );

    // Clock and reset
    always #5 CLK = ~CLK;

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_grant(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({we, a, d});
    endtask

    // Scoreboard: each new memory-port grant is compared against the oldest expected one.
    always @(negedge CLK) begin
        logic [ADDR_W+DATA_W:0] e;
        if (mem_req && !mem_req_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL grant: got access to %0h, expected no access", mem_addr);
            end else begin
                e = exp_q.pop_front();
                chk("grant_we", 64'(mem_we), 64'(e[ADDR_W+DATA_W]));
                chk("grant_addr", 64'(mem_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
                if (e[ADDR_W+DATA_W]) chk("grant_wdata", 64'(mem_wdata), 64'(e[DATA_W-1:0]));
            end
        end
        mem_req_prev = mem_req;
    end

    initial begin
        logic [ADDR_W-1:0] a_if, a_new;
        logic [DATA_W-1:0] rd;

        RST = 1'b0;
        {if_req, ls_req, ls_we, mem_done, id_stall_req, ex_stall_req, branch_taken} = '0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;

        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000011, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000111, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000000, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b001111, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b001111, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b011111, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b011111, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b001111, 1'b1};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000111, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b011111, 1'b0};

        // Reset state
        mid();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_state", 64'(fsm_state), 64'(IDLE));
        chk("rst_starve", 64'(starve_cnt), 64'd0);
        tick();
        RST = 1'b1;
        tick();

        // Stall/flush table: inputs cleared before each edge so the arbiter stays idle
        for (int i = 0; i < 12; i++) begin
            {ls_req, if_req, id_stall_req, ex_stall_req, branch_taken} =
                {vt[i].ls, vt[i].ifr, vt[i].id, vt[i].ex, vt[i].br};
            mid();
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vt[i].stall));
            chk($sformatf("vec%0d_flush", i), 64'(flush), 64'(vt[i].flush));
            #1;
            {ls_req, if_req, id_stall_req, ex_stall_req, branch_taken} = '0;
            tick();
        end
        chk("table_idle", 64'(fsm_state), 64'(IDLE));

        // Reset in the middle of a load; a late mem_done must not produce ls_done
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_1000;
        push_grant(1'b0, 32'h0000_1000, '0);
        tick();
        mid();
        chk("ls_busy_req", 64'(mem_req), 64'd1);
        #2 RST = 1'b0;
        #1;
        chk("arst_mem_req", 64'(mem_req), 64'd0);
        chk("arst_mem_addr", 64'(mem_addr), 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_ls_done", 64'(ls_done), 64'd0);
        chk("arst_state", 64'(fsm_state), 64'(IDLE));
        ls_req = 1'b0;
        tick();
        RST = 1'b1;
        mem_done = 1'b1;
        mid();
        chk("late_done_ls_done", 64'(ls_done), 64'd0);
        tick();
        mem_done = 1'b0;
        mid();
        chk("late_done_mem_req", 64'(mem_req), 64'd0);
        tick();

        // Fetch completing three cycles after grant
        a_if = $urandom; rd = $urandom;
        if_req = 1'b1; if_addr = a_if;
        push_grant(1'b0, a_if, '0);
        mid();
        chk("if_wait_stall", 64'(stall), 64'b000011);
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin mem_done = 1'b1; mem_rdata = rd; end
            mid();
            chk($sformatf("if_busy%0d_req", c), 64'(mem_req), 64'd1);
            chk($sformatf("if_busy%0d_addr", c), 64'(mem_addr), 64'(a_if));
            chk($sformatf("if_busy%0d_stall", c), 64'(stall), (c == 2) ? 64'b000000 : 64'b000011);
            chk($sformatf("if_busy%0d_done", c), 64'(if_done), (c == 2) ? 64'd1 : 64'd0);
            tick();
        end
        chk("if_rdata", 64'(if_rdata), 64'(rd));
        mem_done = 1'b0; if_req = 1'b0;
        mid();
        chk("if_after_req", 64'(mem_req), 64'd0);
        tick();

        // LS wins four times while IF waits, then IF is forced through
        a_if = $urandom;
        if_req = 1'b1; if_addr = a_if; ls_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ls_we = ((k % 2) == 1); ls_addr = $urandom; ls_wdata = $urandom;
            push_grant(ls_we, ls_addr, ls_wdata);
            mid();
            chk($sformatf("starve%0d_stall", k), 64'(stall), 64'b011111);
            tick();
            rd = $urandom; mem_done = 1'b1; mem_rdata = rd;
            mid();
            chk($sformatf("starve%0d_state", k), 64'(fsm_state), 64'(BUSY_LS));
            chk($sformatf("starve%0d_cnt", k), 64'(starve_cnt), 64'(k + 1));
            chk($sformatf("starve%0d_ls_done", k), 64'(ls_done), 64'd1);
            chk($sformatf("starve%0d_rdata", k), 64'(ls_rdata), 64'(rd));
            tick();
            mem_done = 1'b0;
        end
        push_grant(1'b0, a_if, '0);
        mid();
        chk("starve_sat_cnt", 64'(starve_cnt), 64'd4);
        tick();
        mem_done = 1'b1;
        mid();
        chk("starve_if_state", 64'(fsm_state), 64'(BUSY_IF));
        chk("starve_if_cnt", 64'(starve_cnt), 64'd0);
        chk("starve_if_done", 64'(if_done), 64'd1);
        tick();
        mem_done = 1'b0; ls_req = 1'b0; if_req = 1'b0;
        tick();

        // Branch in the second fetch cycle drops the fetch; refetch uses the new PC
        a_if = $urandom; a_new = $urandom;
        if_req = 1'b1; if_addr = a_if;
        push_grant(1'b0, a_if, '0);
        tick();
        tick();
        branch_taken = 1'b1;
        mid();
        chk("br_flush", 64'(flush), 64'd1);
        chk("br_stall", 64'(stall), 64'b000000);
        tick();
        branch_taken = 1'b0; if_addr = a_new;
        mid();
        chk("drop_state", 64'(fsm_state), 64'(DROP_IF));
        chk("drop_mem_req", 64'(mem_req), 64'd1);
        chk("drop_stall", 64'(stall), 64'b000011);
        tick();
        mem_done = 1'b1;
        mid();
        chk("drop_if_done", 64'(if_done), 64'd0);
        push_grant(1'b0, a_new, '0);
        tick();
        mem_done = 1'b0;
        mid();
        chk("drop_idle", 64'(fsm_state), 64'(IDLE));
        tick();
        mem_done = 1'b1; rd = $urandom; mem_rdata = rd;
        mid();
        chk("refetch_done", 64'(if_done), 64'd1);
        tick();
        mem_done = 1'b0;

        // Branch coinciding with fetch completion: no if_done, straight back to IDLE
        a_if = $urandom; if_addr = a_if;
        push_grant(1'b0, a_if, '0);
        tick();
        branch_taken = 1'b1; mem_done = 1'b1;
        mid();
        chk("brdone_if_done", 64'(if_done), 64'd0);
        tick();
        mem_done = 1'b0; branch_taken = 1'b0; if_req = 1'b0;
        mid();
        chk("brdone_state", 64'(fsm_state), 64'(IDLE));
        tick();

        // Branch held under a store: flush only when the store completes
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = $urandom; ls_wdata = $urandom;
        branch_taken = 1'b1; ex_stall_req = 1'b1;
        push_grant(1'b1, ls_addr, ls_wdata);
        mid();
        chk("st_br_flush0", 64'(flush), 64'd0);
        chk("st_br_stall0", 64'(stall), 64'b011111);
        tick();
        mid();
        chk("st_br_flush1", 64'(flush), 64'd0);
        tick();
        ex_stall_req = 1'b0; mem_done = 1'b1;
        mid();
        chk("st_done", 64'(ls_done), 64'd1);
        chk("st_release_flush", 64'(flush), 64'd1);
        chk("st_release_stall", 64'(stall), 64'b000000);
        tick();
        {ls_req, ls_we, branch_taken, mem_done} = '0;
        tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
